rcon: RTL and testbench



---
 rtl/aes_pkg.sv | 28 ++
 rtl/gf_xtime.sv | 11 +
 rtl/rcon.sv | 47 ++++
 tb/tb_rcon.sv | 119 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and the round-constant table used by key expansion.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] round_idx_t;

  localparam byte_t RCON_REDUCE = 8'h1B;

  // Index 1 and 11..15 are never used by the schedule and read as zero.
  function automatic byte_t rcon_lut(input round_idx_t idx);
    byte_t val;
    case (idx)
      4'd0:    val = 8'h36;
      4'd2:    val = 8'h01;
      4'd3:    val = 8'h02;
      4'd4:    val = 8'h04;
      4'd5:    val = 8'h08;
      4'd6:    val = 8'h10;
      4'd7:    val = 8'h20;
      4'd8:    val = 8'h40;
      4'd9:    val = 8'h80;
      4'd10:   val = RCON_REDUCE;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Multiply a GF(2^8) element by x modulo 0x11B; shared with MixColumns.
module gf_xtime
  import aes_pkg::*;
(
  input  byte_t a_i,
  output byte_t y_o
);

  assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? RCON_REDUCE : 8'h00);

endmodule

// File: rtl/rcon.sv
// AES-128 round-constant generator: xtime power chain, index select, one output register.
module rcon
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] roundNum,
  output logic [7:0] out
);

  // pow_w[k] = x^k for k = 0..9; x^9 (0x36) serves the wrap index 0.
  byte_t pow_w [0:9];
  byte_t out_d;
  byte_t out_q;

  assign pow_w[0] = 8'h01;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_chain
      gf_xtime u_xtime (
        .a_i (pow_w[gi]),
        .y_o (pow_w[gi+1])
      );
    end
  endgenerate

  always_comb begin
    out_d = 8'h00;
    if (roundNum == 4'd0) begin
      out_d = pow_w[9];
    end else if ((roundNum >= 4'd2) && (roundNum <= 4'd10)) begin
      out_d = pow_w[roundNum - 4'd2];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_rcon.sv
// Directed checks of the registered AES round-constant generator.
module tb_rcon;

  logic       clk;
  logic       n_rst;
  logic [3:0] roundNum;
  logic [7:0] out;

  int compared;
  int mismatched;

  rcon dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .roundNum (roundNum),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    compared++;
    assert (out === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %02h expected %02h", tag, out, exp);
    end
    $display("check %-12s roundNum=%0d out=%02h expected=%02h", tag, roundNum, out, exp);
  endtask

  // Drive at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [3:0] rn, input logic [7:0] exp, input string tag);
    @(negedge clk);
    roundNum = rn;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  logic [3:0] sweep_idx [0:8];
  logic [7:0] sweep_exp [0:8];

  initial begin
    compared   = 0;
    mismatched = 0;
    sweep_idx = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B};

    // Initial reset pulse, then load a known nonzero value.
    n_rst    = 1'b0;
    roundNum = 4'd5;
    #2;
    n_rst = 1'b1;
    step(4'd5, 8'h08, "preload");

    // Async reset mid-cycle, no clock edge involved.
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_async", 8'h00);
    @(posedge clk); #1;
    check("rst_hold1", 8'h00);
    @(posedge clk); #1;
    check("rst_hold2", 8'h00);

    @(negedge clk);
    n_rst    = 1'b1;
    roundNum = 4'd2;
    #1;
    check("rel_noedge", 8'h00);
    @(posedge clk); #1;
    check("rel_first", 8'h01);

    for (int i = 0; i < 9; i++) begin
      step(sweep_idx[i], sweep_exp[i], $sformatf("sweep_%0d", sweep_idx[i]));
    end

    step(4'd0, 8'h36, "wrap_0");
    step(4'd2, 8'h01, "wrap_2");

    step(4'd1,  8'h00, "unused_1");
    step(4'd11, 8'h00, "unused_11");
    step(4'd15, 8'h00, "unused_15");

    // Latency: input change mid-cycle is invisible until the next edge.
    step(4'd4, 8'h04, "pre_hold");
    @(negedge clk);
    roundNum = 4'd9;
    #1;
    check("hold_old", 8'h04);
    @(posedge clk); #1;
    check("hold_new", 8'h80);
    for (int i = 0; i < 3; i++) begin
      step(4'd9, 8'h80, $sformatf("hold9_%0d", i));
    end

    // Mid-run reset during a sweep.
    for (int i = 0; i < 5; i++) begin
      step(sweep_idx[i], sweep_exp[i], $sformatf("resweep_%0d", sweep_idx[i]));
    end
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst", 8'h00);
    @(negedge clk);
    roundNum = 4'd7;
    n_rst    = 1'b1;
    #1;
    check("midrel_pre", 8'h00);
    @(posedge clk); #1;
    check("midrel_7", 8'h20);
    step(4'd8, 8'h40, "resume_8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
